i2c_tx_scheduler: RTL and testbench

//  Shares one i2c_tx transmitter among REQUESTERS clients with round-robin arbitration.
//  Per transaction, latches the winner's BYTES-byte payload and loads it into i2c_tx.

---
 rtl/i2c_tx_scheduler_if.sv | 38 +++
 rtl/i2c_tx_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_i2c_tx_scheduler.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_tx_scheduler_if.sv
// Purpose: client-side and i2c_tx-side signal bundle for i2c_tx_scheduler.
// Latency: none; this is wiring only.
// Backpressure: clients hold req/req_data until ack; no ack is given while the scheduler is busy.
// Ports: master = application/bench side (drives req, req_data, i2c_clock),
//        slave  = scheduler side (drives ack, done, done_id, busy, tx_rd_en, tx_index, tx_data).
interface i2c_tx_scheduler_if #(
    parameter int REQUESTERS = 2,
    parameter int BYTES      = 2
);
    localparam int ID_W  = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    // client request side
    logic [REQUESTERS-1:0]         req;
    logic [REQUESTERS*8*BYTES-1:0] req_data;
    logic [REQUESTERS-1:0]         ack;

    // status
    logic                          done;
    logic [ID_W-1:0]               done_id;
    logic                          busy;

    // i2c_tx side
    logic                          i2c_clock;
    logic                          tx_rd_en;
    logic [IDX_W-1:0]              tx_index;
    logic [7:0]                    tx_data;

    modport master (
        output req, req_data, i2c_clock,
        input  ack, done, done_id, busy, tx_rd_en, tx_index, tx_data
    );

    modport slave (
        input  req, req_data, i2c_clock,
        output ack, done, done_id, busy, tx_rd_en, tx_index, tx_data
    );
endinterface

// File: rtl/i2c_tx_scheduler.sv
// Purpose: round-robin sharing of one i2c_tx among REQUESTERS clients; latches the winner's payload and loads it byte by byte.
// Latency: ack one clk after req is sampled in IDLE, BYTES load strobes follow, done TX_PERIODS i2c_clock rises after the load.
// Backpressure: while loading or waiting no request is acked; clients keep req/req_data stable until their ack.
// Ports: clk, rst_n (synchronous, active-low); bus (slave modport) carrying req/req_data/ack,
//        done/done_id/busy, the asynchronous i2c_clock input and the tx_rd_en/tx_index/tx_data load strobe.
module i2c_tx_scheduler #(
    parameter int REQUESTERS  = 2,
    parameter int BYTES       = 2,
    parameter int TX_PERIODS  = 27,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    i2c_tx_scheduler_if.slave bus
);
    localparam int ID_W  = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int B_W   = $clog2(BYTES + 1);
    localparam int CNT_W = $clog2(TX_PERIODS + 1);
    localparam int PAY_W = 8 * BYTES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } state_t;

    // registered state
    state_t                state_q, state_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [PAY_W-1:0]      payload_q, payload_d;
    logic [B_W-1:0]        b_q, b_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [REQUESTERS-1:0] ack_q, ack_d;
    logic                  done_q, done_d;
    logic [ID_W-1:0]       done_id_q, done_id_d;
    logic                  rd_en_q, rd_en_d;
    logic [IDX_W-1:0]      index_q, index_d;
    logic [7:0]            data_q, data_d;

    // i2c_clock synchroniser and rise detector
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise;

    // arbitration results
    logic                  grant_vld;
    logic [ID_W-1:0]       grant_id;
    logic [PAY_W-1:0]      grant_payload;
    logic [REQUESTERS-1:0] grant_onehot;
    logic [7:0]            byte_sel;
    logic [CNT_W-1:0]      cnt_inc;

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

    // Round-robin pick: the lowest requester at or above the pointer wins;
    // if none sits there, wrap to the lowest requester overall. Scanning
    // downward and overwriting leaves the lowest index in each candidate.
    always_comb begin
        logic          hi_vld;
        logic [ID_W-1:0] hi_id;
        logic          lo_vld;
        logic [ID_W-1:0] lo_id;
        hi_vld = 1'b0;
        hi_id  = '0;
        lo_vld = 1'b0;
        lo_id  = '0;
        for (int k = REQUESTERS - 1; k >= 0; k--) begin
            if (bus.req[k]) begin
                lo_vld = 1'b1;
                lo_id  = ID_W'(k);
                if (ID_W'(k) >= ptr_q) begin
                    hi_vld = 1'b1;
                    hi_id  = ID_W'(k);
                end
            end
        end
        grant_vld = lo_vld;
        grant_id  = hi_vld ? hi_id : lo_id;
    end

    // Payload and one-hot ack of the winner, selected with constant indices.
    always_comb begin
        grant_payload = '0;
        grant_onehot  = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            if (grant_id == ID_W'(k)) begin
                grant_payload   = bus.req_data[k*PAY_W +: PAY_W];
                grant_onehot[k] = 1'b1;
            end
        end
    end

    // Byte b of the latched payload.
    always_comb begin
        byte_sel = '0;
        for (int j = 0; j < BYTES; j++) begin
            if (b_q == B_W'(j)) begin
                byte_sel = payload_q[j*8 +: 8];
            end
        end
    end

    // Edge counter, saturating at TX_PERIODS.
    always_comb begin
        cnt_inc = cnt_q;
        if (rise && (cnt_q != CNT_W'(TX_PERIODS))) begin
            cnt_inc = cnt_q + 1'b1;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        payload_d = payload_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        ack_d     = '0;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        rd_en_d   = 1'b0;
        index_d   = index_q;
        data_d    = data_q;

        unique case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    id_d      = grant_id;
                    payload_d = grant_payload;
                    ack_d     = grant_onehot;
                    ptr_d     = (grant_id == ID_W'(REQUESTERS - 1)) ? '0 : grant_id + 1'b1;
                    b_d       = '0;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                // Rises seen here are deliberately dropped: the
                // transmitter only starts once its buffer is loaded.
                rd_en_d = 1'b1;
                index_d = b_q[IDX_W-1:0];
                data_d  = byte_sel;
                if (b_q == B_W'(BYTES - 1)) begin
                    b_d     = '0;
                    cnt_d   = '0;
                    state_d = WAIT;
                end else begin
                    b_d = b_q + 1'b1;
                end
            end
            WAIT: begin
                cnt_d = cnt_inc;
                if (cnt_inc == CNT_W'(TX_PERIODS)) begin
                    done_d    = 1'b1;
                    done_id_d = id_q;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            id_q      <= '0;
            payload_q <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            ack_q     <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            rd_en_q   <= 1'b0;
            index_q   <= '0;
            data_q    <= '0;
            sync_q    <= '0;
            prev_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            payload_q <= payload_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            rd_en_q   <= rd_en_d;
            index_q   <= index_d;
            data_q    <= data_d;
            sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.i2c_clock};
            prev_q    <= sync_q[SYNC_STAGES-1];
        end
    end

    assign bus.ack      = ack_q;
    assign bus.done     = done_q;
    assign bus.done_id  = done_id_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.tx_rd_en = rd_en_q;
    assign bus.tx_index = index_q;
    assign bus.tx_data  = data_q;
endmodule

// File: tb/tb_i2c_tx_scheduler.sv
// Purpose: directed, self-checking bench for i2c_tx_scheduler (2 clients, 2 bytes, 27 periods).
// Latency: expectations are hand-derived cycle offsets (ack -> first strobe +1, done -> next ack +1).
// Backpressure: exercises requests arriving while the scheduler is busy.
module tb_i2c_tx_scheduler;
    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    i2c_tx_scheduler_if #(.REQUESTERS(2), .BYTES(2)) bus ();

    i2c_tx_scheduler #(
        .REQUESTERS (2),
        .BYTES      (2),
        .TX_PERIODS (27),
        .SYNC_STAGES(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct { int cyc; logic [1:0] vec; } ack_rec_t;
    typedef struct { int cyc; logic idx; logic [7:0] dat; } tx_rec_t;
    typedef struct { int cyc; logic id; } done_rec_t;

    ack_rec_t  ack_log[$];
    tx_rec_t   tx_log[$];
    done_rec_t done_log[$];

    initial begin
        clk = 1'b0;
        forever #41.5ns clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Observation log, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.ack != 2'b00) ack_log.push_back('{cyc, bus.ack});
        if (bus.tx_rd_en === 1'b1) tx_log.push_back('{cyc, bus.tx_index, bus.tx_data});
        if (bus.done === 1'b1) done_log.push_back('{cyc, bus.done_id});
    end

    initial begin
        #3ms;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req = 2'b00;
        bus.i2c_clock = 1'b0;
        repeat (3) @(negedge clk);
        #1ns;
        ack_log.delete();
        tx_log.delete();
        done_log.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_acks(input int n, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            #1ns;
            if (ack_log.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic i2c_pulses(input int n, input int half_ns);
        for (int i = 0; i < n; i++) begin
            bus.i2c_clock = 1'b1;
            #(half_ns * 1ns);
            bus.i2c_clock = 1'b0;
            #(half_ns * 1ns);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req = 2'b11;
        bus.req_data = 32'h5678_1234;
        bus.i2c_clock = 1'b0;
        repeat (3) @(negedge clk);
        #1ns;
        checks++; if (bus.ack !== 2'b00) begin failures++; $display("FAIL reset_ack got=%b want=00", bus.ack); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bus.done); end
        checks++; if (bus.done_id !== 1'b0) begin failures++; $display("FAIL reset_done_id got=%b want=0", bus.done_id); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        checks++; if (bus.tx_rd_en !== 1'b0) begin failures++; $display("FAIL reset_tx_rd_en got=%b want=0", bus.tx_rd_en); end
        checks++; if (bus.tx_index !== 1'b0) begin failures++; $display("FAIL reset_tx_index got=%b want=0", bus.tx_index); end
        checks++; if (bus.tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h want=00", bus.tx_data); end
        checks++; if (ack_log.size() != 0) begin failures++; $display("FAIL reset_no_ack got=%0d acks want=0", ack_log.size()); end
    endtask

    // Both clients request straight out of reset and keep requesting.
    task automatic test_contention();
        logic [15:0] pay [2];
        logic [1:0]  want_vec;
        bit          ok;
        int          exp_id;
        pay[0] = 16'h1234;
        pay[1] = 16'h5678;
        ack_log.delete();
        tx_log.delete();
        done_log.delete();
        rst_n = 1'b1;
        for (int t = 0; t < 4; t++) begin
            exp_id   = t % 2;
            want_vec = (exp_id == 0) ? 2'b01 : 2'b10;
            wait_acks(t + 1, 40, ok);
            checks++;
            if (!ok) begin
                failures++; $display("FAIL contention_ack_timeout txn=%0d acks=%0d want>=%0d", t, ack_log.size(), t + 1);
            end else begin
                checks++; if (ack_log[t].vec !== want_vec) begin failures++; $display("FAIL contention_grant txn=%0d got=%b want=%b", t, ack_log[t].vec, want_vec); end
                repeat (3) @(negedge clk);
                #1ns;
                checks++;
                if (tx_log.size() < 2 * t + 2) begin
                    failures++; $display("FAIL contention_strobes txn=%0d got=%0d want>=%0d", t, tx_log.size(), 2 * t + 2);
                end else begin
                    checks++; if (tx_log[2*t].dat !== pay[exp_id][7:0]) begin failures++; $display("FAIL contention_byte0 txn=%0d got=%h want=%h", t, tx_log[2*t].dat, pay[exp_id][7:0]); end
                    checks++; if (tx_log[2*t+1].dat !== pay[exp_id][15:8]) begin failures++; $display("FAIL contention_byte1 txn=%0d got=%h want=%h", t, tx_log[2*t+1].dat, pay[exp_id][15:8]); end
                    checks++; if (tx_log[2*t].cyc != ack_log[t].cyc + 1) begin failures++; $display("FAIL contention_strobe_cycle txn=%0d got=%0d want=%0d", t, tx_log[2*t].cyc, ack_log[t].cyc + 1); end
                end
            end
            i2c_pulses(27, 500);
            checks++;
            if (done_log.size() != t + 1) begin
                failures++; $display("FAIL contention_done_count txn=%0d got=%0d want=%0d", t, done_log.size(), t + 1);
            end else begin
                checks++; if (done_log[t].id !== exp_id[0]) begin failures++; $display("FAIL contention_done_id txn=%0d got=%b want=%0d", t, done_log[t].id, exp_id); end
            end
        end
        bus.req = 2'b00;
    endtask

    task automatic test_single();
        bit ok;
        do_reset();
        bus.req_data = 32'h0000_AA50;
        bus.req = 2'b01;
        wait_acks(1, 10, ok);
        bus.req = 2'b00;
        checks++; if (!ok) begin failures++; $display("FAIL single_ack_timeout acks=%0d want=1", ack_log.size()); end
        repeat (3) @(negedge clk);
        #1ns;
        checks++; if (ack_log.size() != 1) begin failures++; $display("FAIL single_ack_width got=%0d ack cycles want=1", ack_log.size()); end
        checks++;
        if (tx_log.size() != 2 || ack_log.size() < 1) begin
            failures++; $display("FAIL single_strobe_count got=%0d want=2", tx_log.size());
        end else begin
            checks++; if (ack_log[0].vec !== 2'b01) begin failures++; $display("FAIL single_ack_vec got=%b want=01", ack_log[0].vec); end
            checks++; if (tx_log[0].idx !== 1'b0 || tx_log[0].dat !== 8'h50) begin failures++; $display("FAIL single_strobe0 got=(%b,%h) want=(0,50)", tx_log[0].idx, tx_log[0].dat); end
            checks++; if (tx_log[1].idx !== 1'b1 || tx_log[1].dat !== 8'hAA) begin failures++; $display("FAIL single_strobe1 got=(%b,%h) want=(1,aa)", tx_log[1].idx, tx_log[1].dat); end
            checks++; if (tx_log[0].cyc != ack_log[0].cyc + 1 || tx_log[1].cyc != ack_log[0].cyc + 2) begin failures++; $display("FAIL single_strobe_cycles got=%0d,%0d ack=%0d want=ack+1,ack+2", tx_log[0].cyc, tx_log[1].cyc, ack_log[0].cyc); end
        end
        checks++; if (bus.tx_rd_en !== 1'b0 || bus.tx_index !== 1'b1 || bus.tx_data !== 8'hAA) begin failures++; $display("FAIL single_hold got=(%b,%b,%h) want=(0,1,aa)", bus.tx_rd_en, bus.tx_index, bus.tx_data); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b want=1", bus.busy); end
        i2c_pulses(26, 500);
        checks++; if (done_log.size() != 0) begin failures++; $display("FAIL single_done_early got=%0d want=0", done_log.size()); end
        i2c_pulses(1, 500);
        checks++;
        if (done_log.size() != 1) begin
            failures++; $display("FAIL single_done_count got=%0d want=1", done_log.size());
        end else begin
            checks++; if (done_log[0].id !== 1'b0) begin failures++; $display("FAIL single_done_id got=%b want=0", done_log[0].id); end
        end
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.done_id !== 1'b0) begin failures++; $display("FAIL single_after got busy=%b done=%b id=%b want 0,0,0", bus.busy, bus.done, bus.done_id); end
    endtask

    task automatic test_busy_blocking();
        bit ok;
        do_reset();
        bus.req_data = 32'hC3C3_0F0F;
        bus.req = 2'b01;
        wait_acks(1, 10, ok);
        bus.req = 2'b00;
        checks++; if (!ok) begin failures++; $display("FAIL block_first_ack_timeout acks=%0d want=1", ack_log.size()); end
        repeat (3) @(negedge clk);
        i2c_pulses(10, 500);
        bus.req = 2'b10;
        i2c_pulses(16, 500);
        checks++; if (ack_log.size() != 1) begin failures++; $display("FAIL block_no_ack got=%0d acks want=1", ack_log.size()); end
        checks++; if (tx_log.size() != 2) begin failures++; $display("FAIL block_no_strobe got=%0d want=2", tx_log.size()); end
        i2c_pulses(1, 500);
        checks++; if (done_log.size() != 1) begin failures++; $display("FAIL block_done got=%0d want=1", done_log.size()); end
        wait_acks(2, 10, ok);
        bus.req = 2'b00;
        checks++;
        if (!ok || done_log.size() < 1) begin
            failures++; $display("FAIL block_second_ack_timeout acks=%0d want=2", ack_log.size());
        end else begin
            checks++; if (ack_log[1].vec !== 2'b10) begin failures++; $display("FAIL block_second_vec got=%b want=10", ack_log[1].vec); end
            checks++; if (ack_log[1].cyc != done_log[0].cyc + 1) begin failures++; $display("FAIL block_ack_after_done got=%0d want=%0d", ack_log[1].cyc, done_log[0].cyc + 1); end
        end
        repeat (3) @(negedge clk);
        #1ns;
        checks++; if (tx_log.size() != 4 || tx_log[2].dat !== 8'hC3) begin failures++; $display("FAIL block_second_load got=%0d strobes want=4 with byte0 c3", tx_log.size()); end
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        do_reset();
        bus.req_data = 32'h0000_9966;
        bus.req = 2'b01;
        wait_acks(1, 10, ok);
        bus.req = 2'b00;
        checks++; if (!ok) begin failures++; $display("FAIL midrst_ack_timeout acks=%0d want=1", ack_log.size()); end
        repeat (3) @(negedge clk);
        i2c_pulses(10, 500);
        @(negedge clk);
        #1ns;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1ns;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b want=0", bus.busy); end
        checks++; if (bus.tx_rd_en !== 1'b0 || bus.tx_data !== 8'h00) begin failures++; $display("FAIL midrst_tx got=(%b,%h) want=(0,00)", bus.tx_rd_en, bus.tx_data); end
        rst_n = 1'b1;
        i2c_pulses(20, 500);
        checks++; if (done_log.size() != 0) begin failures++; $display("FAIL midrst_no_done got=%0d want=0", done_log.size()); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_idle got=%b want=0", bus.busy); end
        bus.req = 2'b01;
        wait_acks(2, 10, ok);
        bus.req = 2'b00;
        checks++; if (!ok) begin failures++; $display("FAIL midrst_reack_timeout acks=%0d want=2", ack_log.size()); end
        repeat (3) @(negedge clk);
        i2c_pulses(26, 500);
        checks++; if (done_log.size() != 0) begin failures++; $display("FAIL midrst_done_early got=%0d want=0", done_log.size()); end
        i2c_pulses(1, 500);
        checks++;
        if (done_log.size() != 1) begin
            failures++; $display("FAIL midrst_done got=%0d want=1", done_log.size());
        end else begin
            checks++; if (done_log[0].id !== 1'b0) begin failures++; $display("FAIL midrst_done_id got=%b want=0", done_log[0].id); end
        end
    endtask

    // 20us bit clock; the first rise is launched with the request so that
    // its synchronised edge lands while the bytes are being loaded.
    task automatic test_edge_counting();
        bit ok;
        int rise_cyc;
        do_reset();
        bus.req_data = 32'h0000_3C5A;
        bus.req = 2'b01;
        bus.i2c_clock = 1'b1;
        wait_acks(1, 5, ok);
        bus.req = 2'b00;
        checks++; if (!ok) begin failures++; $display("FAIL edge_ack_timeout acks=%0d want=1", ack_log.size()); end
        #10000ns;
        bus.i2c_clock = 1'b0;
        #10000ns;
        i2c_pulses(26, 10000);
        checks++; if (done_log.size() != 0) begin failures++; $display("FAIL edge_done_early got=%0d want=0", done_log.size()); end
        rise_cyc = cyc;
        bus.i2c_clock = 1'b1;
        #10000ns;
        checks++;
        if (done_log.size() != 1) begin
            failures++; $display("FAIL edge_done_count got=%0d want=1", done_log.size());
        end else begin
            checks++; if (done_log[0].cyc < rise_cyc + 2 || done_log[0].cyc > rise_cyc + 4) begin failures++; $display("FAIL edge_done_latency got=%0d want=%0d..%0d", done_log[0].cyc, rise_cyc + 2, rise_cyc + 4); end
        end
        bus.i2c_clock = 1'b0;
        #10000ns;
        checks++; if (done_log.size() != 1) begin failures++; $display("FAIL edge_single_done got=%0d want=1", done_log.size()); end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.req = 2'b00;
        bus.req_data = '0;
        bus.i2c_clock = 1'b0;
        test_reset();
        test_contention();
        test_single();
        test_busy_blocking();
        test_reset_mid_wait();
        test_edge_counting();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
